// File: rtl/uart_pkg.sv
// uart_pkg: shared UART constants for the receive path.
package uart_pkg;
    localparam int UART_DATA_W        = 8;
    localparam int UART_RX_FIFO_DEPTH = 16;
endpackage

// File: rtl/uart_fifo_mem.sv
// uart_fifo_mem: DEPTH x DATA_W register array, sync write port, async read port, no reset.
module uart_fifo_mem #(
    parameter int DEPTH  = 16,
    parameter int DATA_W = 8
) (
    input  logic                       clk,
    input  logic                       we,
    input  logic [$clog2(DEPTH)-1:0]   waddr,
    input  logic [DATA_W-1:0]          wdata,
    input  logic [$clog2(DEPTH)-1:0]   raddr,
    output logic [DATA_W-1:0]          rdata
);
    logic [DATA_W-1:0] mem [DEPTH];
    always_ff @(posedge clk)
        if (we) mem[waddr] <= wdata;
    assign rdata = mem[raddr];
endmodule

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: captures a byte per rising edge of rx_done into a FIFO
// and presents it over valid/ready, with occupancy and sticky overflow.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH  = UART_RX_FIFO_DEPTH,
    parameter int DATA_W = UART_DATA_W
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [DATA_W-1:0]        rx_data,
    input  logic                     rx_done,
    output logic [DATA_W-1:0]        m_data,
    output logic                     m_valid,
    input  logic                     m_ready,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty,
    output logic                     overflow,
    input  logic                     clr_overflow
);
    localparam int AW = $clog2(DEPTH);
    logic [AW:0] wr_ptr, rd_ptr;
    logic        done_q, wr_evt, rd_evt, wr_ok;
    assign wr_evt  = rx_done & ~done_q;
    assign rd_evt  = m_valid & m_ready;
    assign wr_ok   = wr_evt & (~full | rd_evt);
    assign empty   = wr_ptr == rd_ptr;
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign count   = wr_ptr - rd_ptr;
    assign m_valid = ~empty;
    // done_q resets high so a level already asserted at reset release is ignored
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            done_q   <= 1'b1;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            overflow <= 1'b0;
        end else begin
            done_q   <= rx_done;
            if (wr_ok)  wr_ptr <= wr_ptr + 1'b1;
            if (rd_evt) rd_ptr <= rd_ptr + 1'b1;
            overflow <= (wr_evt & full & ~rd_evt) | (overflow & ~clr_overflow);
        end
    uart_fifo_mem #(.DEPTH(DEPTH), .DATA_W(DATA_W)) u_mem (
        .clk   (clk),
        .we    (wr_ok),
        .waddr (wr_ptr[AW-1:0]),
        .wdata (rx_data),
        .raddr (rd_ptr[AW-1:0]),
        .rdata (m_data)
    );
endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: directed stimulus with a byte scoreboard; a monitor pops
// expected bytes on every handshake while direct checks cover flags and count.
module tb_uart_rx_fifo;
    logic       clk = 1'b0, rst = 1'b1, rx_done = 1'b0, m_ready = 1'b0, clr_overflow = 1'b0;
    logic [7:0] rx_data = '0, m_data;
    logic       m_valid, full, empty, overflow;
    logic [4:0] count;
    int         n_cmp = 0, n_err = 0;
    logic [7:0] sb [$];

    uart_rx_fifo #(.DEPTH(16), .DATA_W(8)) dut (
        .clk(clk), .rst(rst), .rx_data(rx_data), .rx_done(rx_done),
        .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .count(count),
        .full(full), .empty(empty), .overflow(overflow), .clr_overflow(clr_overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Inputs are stable by the falling edge, so a handshake seen here completes next posedge
    always @(negedge clk)
        if (!rst && m_valid && m_ready) begin
            if (sb.size() == 0) begin
                n_cmp++; n_err++;
                $display("FAIL unexpected_byte: got 0x%0h expected none", m_data);
            end else check("m_data", m_data, sb.pop_front());
        end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic send(input logic [7:0] b, input bit keep);
        rx_data = b; rx_done = 1'b1;
        tick();
        rx_done = 1'b0;
        if (keep) sb.push_back(b);
        tick();
    endtask

    task automatic drain();
        m_ready = 1'b1;
        for (int i = 0; i < 64 && !empty; i++) tick();
        m_ready = 1'b0;
        check("drain_empty", empty, 1);
        check("sb_left", sb.size(), 0);
    endtask

    task automatic fill(input logic [7:0] base);
        for (int i = 0; i < 16; i++) send(base + 8'(i), 1'b1);
    endtask

    initial begin
        // 1: rx_done high across reset release is not captured
        rx_done = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        repeat (3) tick();
        check("t1_empty", empty, 1);
        check("t1_count", count, 0);
        check("t1_valid", m_valid, 0);
        check("t1_full", full, 0);
        check("t1_ovf", overflow, 0);
        rx_done = 1'b0;
        tick();
        // 2: single byte, next-cycle visibility
        rx_data = 8'hA5; rx_done = 1'b1;
        tick();
        rx_done = 1'b0;
        sb.push_back(8'hA5);
        check("t2_valid", m_valid, 1);
        check("t2_data", m_data, 8'hA5);
        check("t2_count", count, 1);
        tick();
        m_ready = 1'b1;
        tick();
        m_ready = 1'b0;
        check("t2_empty", empty, 1);
        check("t2_count0", count, 0);
        // 3: held rx_done yields one entry
        rx_data = 8'h3C; rx_done = 1'b1;
        repeat (20) tick();
        rx_done = 1'b0;
        sb.push_back(8'h3C);
        tick();
        check("t3_count", count, 1);
        drain();
        // 4: overfill by one
        for (int i = 0; i < 17; i++) send(8'(i), i < 16);
        check("t4_full", full, 1);
        check("t4_count", count, 16);
        check("t4_ovf", overflow, 1);
        drain();
        // 5: full with simultaneous write and read
        clr_overflow = 1'b1;
        tick();
        clr_overflow = 1'b0;
        check("t5_clr", overflow, 0);
        fill(8'h40);
        rx_data = 8'h99; rx_done = 1'b1; m_ready = 1'b1;
        sb.push_back(8'h99);
        tick();
        rx_done = 1'b0; m_ready = 1'b0;
        tick();
        check("t5_count", count, 16);
        check("t5_full", full, 1);
        check("t5_ovf", overflow, 0);
        drain();
        // 6: overflow clear, and set winning over a coincident clear
        fill(8'h60);
        send(8'hDD, 1'b0);
        check("t6_ovf_set", overflow, 1);
        clr_overflow = 1'b1;
        tick();
        clr_overflow = 1'b0;
        check("t6_ovf_clr", overflow, 0);
        rx_data = 8'hEE; rx_done = 1'b1; clr_overflow = 1'b1;
        tick();
        rx_done = 1'b0; clr_overflow = 1'b0;
        tick();
        check("t6_ovf_win", overflow, 1);
        check("t6_count", count, 16);
        drain();
        // interleaved traffic across pointer wrap
        m_ready = 1'b1;
        for (int i = 0; i < 40; i++) send(8'h80 + 8'(i), 1'b1);
        m_ready = 1'b0;
        drain();
        check("t6_count0", count, 0);
        // reset mid-operation clears immediately
        for (int i = 0; i < 3; i++) send(8'hF0 + 8'(i), 1'b0);
        check("t7_pre", count, 3);
        rst = 1'b1;
        #1;
        check("t7_count", count, 0);
        check("t7_empty", empty, 1);
        check("t7_ovf", overflow, 0);
        tick();
        rst = 1'b0;
        tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
